// File: rtl/riscv_pkg.sv
// RV32I opcode constants and instruction-format classification shared by the encoder and the decoder.
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_J   = 3'd4,
    FMT_U   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic        fn7_5;
    logic [11:0] imm;
    logic [19:0] imm_uj;
  } fields_t;

  function automatic fmt_e op_format(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:                   f = FMT_R;
      OP_ITYPE, OP_LOAD, OP_JALR: f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_JAL:                     f = FMT_J;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      default:                    f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// Synchronous FIFO with async active-low reset and synchronous flush; reads a zero word when empty.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: reads are masked by empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs decoded fields into instruction words, queues them and
// emits each with a sequential byte address; unsupported opcodes are consumed and counted.
`default_nettype none

module instr_encoder
  import riscv_pkg::*;
#(
  parameter int            DEPTH     = 4,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             fn3,
  input  logic                   fn7_5,
  input  logic [11:0]            imm,
  input  logic [19:0]            imm_uj,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [AW-1:0]          out_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   illegal,
  output logic [7:0]             illegal_cnt
);

  function automatic logic [31:0] encode(input fields_t f, input fmt_e fmt);
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {1'b0, f.fn7_5, 5'b0, f.rs2, f.rs1, f.fn3, f.rd, f.opcode};
      FMT_I:   w = {f.imm, f.rs1, f.fn3, f.rd, f.opcode};
      FMT_S:   w = {f.imm[11:5], f.rs2, f.rs1, f.fn3, f.imm[4:0], f.opcode};
      // imm holds offset[12:1], so indices here are one below the ISA offset bits.
      FMT_B:   w = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, f.fn3, f.imm[3:0], f.imm[10], f.opcode};
      FMT_J:   w = {f.imm_uj[19], f.imm_uj[9:0], f.imm_uj[10], f.imm_uj[18:11], f.rd, f.opcode};
      FMT_U:   w = {f.imm_uj, f.rd, f.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

  fields_t     fields;
  fmt_e        fmt;
  logic        legal;
  logic [31:0] word;
  logic        push;
  logic        pop;
  logic        fifo_push;
  logic        full;
  logic        empty;

  always_comb begin
    fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, fn3: fn3,
               fn7_5: fn7_5, imm: imm, imm_uj: imm_uj};
    fmt    = op_format(opcode);
    legal  = (fmt != FMT_BAD);
    word   = encode(fields, fmt);
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign fifo_push = push && legal && !flush;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (flush),
    .push  (fifo_push),
    .wdata (word),
    .pop   (pop),
    .rdata (out_instr),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_addr    <= BASE_ADDR;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_addr    <= BASE_ADDR;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (pop) out_addr <= out_addr + AW'(4);
      illegal <= push && !legal;
      if (push && !legal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic against a queue model.
`default_nettype none

module tb_instr_encoder;

  localparam int            DEPTH = 4;
  localparam int            AW    = 32;
  localparam logic [AW-1:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  fn3 = '0;
  logic        fn7_5 = 1'b0;
  logic [11:0] imm = '0;
  logic [19:0] imm_uj = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [$clog2(DEPTH):0] count;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0]   q[$];
  logic [AW-1:0] m_addr = BASE;
  bit            m_ill  = 1'b0;
  int            m_icnt = 0;

  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
  logic [6:0] bad_ops   [4] = '{7'h7F, 7'h0F, 7'h73, 7'h00};

  instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .fn3(fn3), .fn7_5(fn7_5),
    .imm(imm), .imm_uj(imm_uj), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // ISA-level encoding built from the byte offsets, not the packed immediate fields.
  function automatic void ref_encode(output logic [31:0] w, output bit legal);
    logic [31:0] off;
    legal = 1'b1;
    case (opcode)
      7'h33: w = ({31'd0, fn7_5} << 30) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(fn3) << 12) | (32'(rd) << 7) | 32'(opcode);
      7'h13, 7'h03, 7'h67:
             w = (32'(imm) << 20) | (32'(rs1) << 15) | (32'(fn3) << 12) | (32'(rd) << 7) | 32'(opcode);
      7'h23: w = ((32'(imm) >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(fn3) << 12)
                 | ((32'(imm) & 32'h1F) << 7) | 32'(opcode);
      7'h63: begin
        off = 32'(imm) * 2;
        w = (((off >> 12) & 1) << 31) | (((off >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
            | (32'(fn3) << 12) | (((off >> 1) & 32'hF) << 8) | (((off >> 11) & 1) << 7) | 32'(opcode);
      end
      7'h6F: begin
        off = 32'(imm_uj) * 2;
        w = (((off >> 20) & 1) << 31) | (((off >> 1) & 32'h3FF) << 21) | (((off >> 11) & 1) << 20)
            | (((off >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(opcode);
      end
      7'h37, 7'h17: w = (32'(imm_uj) * 32'h1000) | (32'(rd) << 7) | 32'(opcode);
      default: begin w = '0; legal = 1'b0; end
    endcase
  endfunction

  // Advance one clock, applying the same edge to the model first.
  task automatic tick();
    bit p, r, legal;
    logic [31:0] w;
    if (flush) begin
      q.delete(); m_addr = BASE; m_ill = 1'b0; m_icnt = 0;
    end else begin
      r = (q.size() > 0) && out_ready;
      p = in_valid && (q.size() < DEPTH);
      if (r) begin void'(q.pop_front()); m_addr = m_addr + 4; end
      m_ill = 1'b0;
      if (p) begin
        ref_encode(w, legal);
        if (legal) q.push_back(w);
        else begin m_ill = 1'b1; if (m_icnt < 255) m_icnt++; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_fields(input logic [6:0] op);
    opcode = op; rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    fn3 = 3'($urandom); fn7_5 = 1'($urandom); imm = 12'($urandom); imm_uj = 20'($urandom);
  endtask

  task automatic model_reset();
    q.delete(); m_addr = BASE; m_ill = 1'b0; m_icnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    n_checks++; if (out_addr !== BASE) begin n_fail++; $display("FAIL reset_out_addr got %h want %h", out_addr, BASE); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (illegal !== 1'b0 || illegal_cnt !== 8'h0) begin n_fail++;
      $display("FAIL reset_illegal got %0b/%h want 0/00", illegal, illegal_cnt); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_vectors();
    logic [6:0]  v_op [6] = '{7'h33, 7'h33, 7'h13, 7'h23, 7'h37, 7'h6F};
    logic [4:0]  v_rd [6] = '{5'd3, 5'd5, 5'd1, 5'd0, 5'd1, 5'd1};
    logic [4:0]  v_r1 [6] = '{5'd1, 5'd6, 5'd0, 5'd1, 5'd0, 5'd0};
    logic [4:0]  v_r2 [6] = '{5'd2, 5'd7, 5'd0, 5'd2, 5'd0, 5'd0};
    logic [2:0]  v_f3 [6] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0};
    logic        v_f7 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] v_im [6] = '{12'd0, 12'd0, 12'd5, 12'd8, 12'd0, 12'd0};
    logic [19:0] v_uj [6] = '{20'h0, 20'h0, 20'h0, 20'h0, 20'h12345, 20'h00002};
    logic [31:0] v_ex [6] = '{32'h002081B3, 32'h407302B3, 32'h00500093, 32'h0020A423, 32'h123450B7, 32'h004000EF};
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = v_op[i]; rd = v_rd[i]; rs1 = v_r1[i]; rs2 = v_r2[i]; fn3 = v_f3[i];
      fn7_5 = v_f7[i]; imm = v_im[i]; imm_uj = v_uj[i]; in_valid = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_instr !== v_ex[i]) begin n_fail++;
        $display("FAIL vector_%0d instr got %h (valid %0b) want %h", i, out_instr, out_valid, v_ex[i]); end
      n_checks++; if (out_addr !== AW'(4 * i)) begin n_fail++;
        $display("FAIL vector_%0d addr got %h want %h", i, out_addr, 4 * i); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vector_drain out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_fields(legal_ops[$urandom_range(0, 8)]); in_valid = 1'b1;
      n_checks++; if (in_ready !== (i < DEPTH)) begin n_fail++;
        $display("FAIL bp_in_ready_%0d got %0b want %0b", i, in_ready, i < DEPTH); end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'(DEPTH) || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_full count got %0d ready %0b want %0d/0", count, in_ready, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (out_addr !== AW'(4 * i) || out_instr !== q[0]) begin n_fail++;
        $display("FAIL bp_drain_%0d got %h@%h want %h@%h", i, out_instr, out_addr, q[0], 4 * i); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0 || count !== '0) begin n_fail++;
      $display("FAIL bp_empty valid %0b count %0d want 0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    flush = 1'b1; tick(); flush = 1'b0;
    rand_fields(7'h7F); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (illegal !== 1'b1 || illegal_cnt !== 8'd1) begin n_fail++;
      $display("FAIL illegal_pulse got %0b cnt %h want 1 cnt 01", illegal, illegal_cnt); end
    n_checks++; if (count !== '0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL illegal_nowrite count %0d valid %0b want 0/0", count, out_valid); end
    tick();
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle got %0b want 0", illegal); end
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin rand_fields(bad_ops[$urandom_range(0, 3)]); tick(); end
    in_valid = 1'b0;
    n_checks++; if (illegal_cnt !== 8'hFF || illegal !== 1'b1) begin n_fail++;
      $display("FAIL illegal_saturate cnt %h pulse %0b want FF/1", illegal_cnt, illegal); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_fields(legal_ops[$urandom_range(0, 8)]); tick(); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre count got %0d want 3", count); end
    rand_fields(legal_ops[0]); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== '0 || out_valid !== 1'b0 || illegal_cnt !== 8'h0) begin n_fail++;
      $display("FAIL flush_clear count %0d valid %0b icnt %h want 0/0/00", count, out_valid, illegal_cnt); end
    rand_fields(legal_ops[1]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== BASE || out_instr !== q[0]) begin n_fail++;
      $display("FAIL flush_next got %h@%h want %h@%h", out_instr, out_addr, q[0], BASE); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) rand_fields(bad_ops[$urandom_range(0, 3)]);
      else rand_fields(legal_ops[$urandom_range(0, 8)]);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
      flush = 1'b0;
      n_checks++;
      if (out_valid !== (q.size() > 0) || count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)
          || out_addr !== m_addr || illegal !== m_ill || illegal_cnt !== 8'(m_icnt)
          || (q.size() > 0 && out_instr !== q[0])) begin
        n_fail++;
        $display("FAIL random_%0d got v%0b c%0d r%0b %h@%h il%0b ic%h want c%0d %h@%h il%0b ic%h",
                 c, out_valid, count, in_ready, out_instr, out_addr, illegal, illegal_cnt,
                 q.size(), (q.size() > 0) ? q[0] : 32'h0, m_addr, m_ill, m_icnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_fields(legal_ops[$urandom_range(0, 8)]); tick(); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || count !== '0 || out_instr !== 32'h0 || out_addr !== BASE
                    || in_ready !== 1'b1 || illegal !== 1'b0 || illegal_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid got v%0b c%0d %h@%h r%0b il%0b ic%h want all reset values",
               out_valid, count, out_instr, out_addr, in_ready, illegal, illegal_cnt);
    end
    model_reset();
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_illegal();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
